// File: rtl/mfp_multi_digit_display_scanner.sv
// Multiplexed N-digit seven-segment scanner: frame-coherent snapshot, leading-zero
// blanking, per-digit dot/enable, PWM brightness with a dead cycle at each slot start.
module mfp_multi_digit_display_scanner #(
    parameter int N_DIGITS     = 8,
    parameter int REFRESH_LOG2 = 14,
    parameter int BRIGHT_W     = 4,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*N_DIGITS-1:0]   number,
    input  logic [N_DIGITS-1:0]     dots,
    input  logic [N_DIGITS-1:0]     digit_enable,
    input  logic                    blank_lz,
    input  logic [BRIGHT_W-1:0]     brightness,
    output logic [6:0]              seven_segments,
    output logic                    dot,
    output logic [N_DIGITS-1:0]     anodes,
    output logic                    frame_start
);

    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N_DIGITS - 1);
    localparam logic POL = (ACTIVE_LOW != 0);

    logic [REFRESH_LOG2-1:0] cnt;
    logic [IDX_W-1:0]        idx;
    logic [4*N_DIGITS-1:0]   snap_num;
    logic [N_DIGITS-1:0]     snap_dots;
    logic [N_DIGITS-1:0]     snap_en;
    logic                    snap_blz;

    logic                    slot_end, frame_end;
    logic [N_DIGITS:0]       zero_from;
    logic [N_DIGITS-1:0]     blanked;
    logic [3:0]              nib;
    logic                    sel_en, sel_dot, sel_blank, lit;
    logic [N_DIGITS-1:0]     an_hi;
    logic [6:0]              seg_hi;
    logic [BRIGHT_W-1:0]     phase;

    assign slot_end  = &cnt;
    assign frame_end = slot_end && (idx == LAST);
    assign phase     = cnt[REFRESH_LOG2-1 -: BRIGHT_W];

    always_comb begin
        zero_from           = '0;
        zero_from[N_DIGITS] = 1'b1;
        for (int i = N_DIGITS - 1; i >= 0; i--)
            zero_from[i] = zero_from[i+1] && (snap_num[4*i +: 4] == 4'h0);
        blanked = '0;
        // Digit 0 is never blanked so an all-zero value still reads "0".
        for (int i = 1; i < N_DIGITS; i++)
            blanked[i] = snap_blz && zero_from[i];
    end

    always_comb begin
        nib       = 4'h0;
        sel_en    = 1'b0;
        sel_dot   = 1'b0;
        sel_blank = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                nib       = snap_num[4*i +: 4];
                sel_en    = snap_en[i];
                sel_dot   = snap_dots[i];
                sel_blank = blanked[i];
            end
        end
        lit   = (cnt != '0) && (phase <= brightness) && sel_en && !sel_blank;
        an_hi = '0;
        for (int i = 0; i < N_DIGITS; i++)
            an_hi[i] = lit && (idx == IDX_W'(i));
    end

    always_comb begin
        case (nib)
            4'h0: seg_hi = 7'h3F;
            4'h1: seg_hi = 7'h06;
            4'h2: seg_hi = 7'h5B;
            4'h3: seg_hi = 7'h4F;
            4'h4: seg_hi = 7'h66;
            4'h5: seg_hi = 7'h6D;
            4'h6: seg_hi = 7'h7D;
            4'h7: seg_hi = 7'h07;
            4'h8: seg_hi = 7'h7F;
            4'h9: seg_hi = 7'h6F;
            4'hA: seg_hi = 7'h77;
            4'hB: seg_hi = 7'h7C;
            4'hC: seg_hi = 7'h39;
            4'hD: seg_hi = 7'h5E;
            4'hE: seg_hi = 7'h79;
            default: seg_hi = 7'h71;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt            <= '0;
            idx            <= '0;
            snap_num       <= '0;
            snap_dots      <= '0;
            snap_en        <= '0;
            snap_blz       <= 1'b0;
            seven_segments <= {7{POL}};
            dot            <= POL;
            anodes         <= {N_DIGITS{POL}};
            frame_start    <= 1'b0;
        end else begin
            cnt <= cnt + 1'b1;
            if (slot_end)
                idx <= (idx == LAST) ? '0 : idx + 1'b1;
            // Capture at the frame boundary so a whole frame shows one coherent value.
            if (frame_end) begin
                snap_num  <= number;
                snap_dots <= dots;
                snap_en   <= digit_enable;
                snap_blz  <= blank_lz;
            end
            seven_segments <= (lit ? seg_hi : 7'h00) ^ {7{POL}};
            dot            <= (lit && sel_dot) ^ POL;
            anodes         <= an_hi ^ {N_DIGITS{POL}};
            frame_start    <= frame_end;
        end
    end

endmodule

// File: tb/tb_mfp_multi_digit_display_scanner.sv
// Directed bench for the display scanner: 4-digit instance, plus a 3-digit instance
// for the non-power-of-two slot wrap.
module tb_mfp_multi_digit_display_scanner;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] number;
    logic [3:0]  dots, digit_enable;
    logic        blank_lz;
    logic [1:0]  brightness;
    logic [6:0]  seven_segments;
    logic        dot;
    logic [3:0]  anodes;
    logic        frame_start;

    logic [11:0] number3;
    logic [6:0]  seven_segments3;
    logic        dot3;
    logic [2:0]  anodes3;
    logic        frame_start3;

    int checks = 0;
    int errors = 0;

    logic [3:0] an_s  [256];
    logic [6:0] seg_s [256];
    logic       dot_s [256];

    always #5 clk = ~clk;

    mfp_multi_digit_display_scanner #(
        .N_DIGITS(4), .REFRESH_LOG2(6), .BRIGHT_W(2), .ACTIVE_LOW(1)
    ) u_dut (
        .clk(clk), .reset(reset), .number(number), .dots(dots),
        .digit_enable(digit_enable), .blank_lz(blank_lz), .brightness(brightness),
        .seven_segments(seven_segments), .dot(dot), .anodes(anodes),
        .frame_start(frame_start)
    );

    mfp_multi_digit_display_scanner #(
        .N_DIGITS(3), .REFRESH_LOG2(6), .BRIGHT_W(2), .ACTIVE_LOW(1)
    ) u_dut3 (
        .clk(clk), .reset(reset), .number(number3), .dots(3'b000),
        .digit_enable(3'b111), .blank_lz(1'b0), .brightness(2'd3),
        .seven_segments(seven_segments3), .dot(dot3), .anodes(anodes3),
        .frame_start(frame_start3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Returns at a negedge where frame_start is high (checks the current cycle first).
    task automatic wait_frame();
        int n = 0;
        while (!frame_start && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!frame_start) chk("frame_timeout", 32'd0, 32'd1);
    endtask

    task automatic new_frame();
        @(negedge clk);
        wait_frame();
    endtask

    // Sample position p = idx*64 + cnt of the frame just started; optionally change number at chg_p.
    task automatic measure_frame(input int chg_p, input logic [15:0] chg_num);
        for (int p = 0; p < 256; p++) begin
            @(negedge clk);
            an_s[p]  = anodes;
            seg_s[p] = seven_segments;
            dot_s[p] = dot;
            if (p == chg_p) number = chg_num;
        end
    endtask

    function automatic int lit_cnt(input int d);
        logic [3:0] m;
        int c = 0;
        m = ~(4'b0001 << d);
        for (int p = d * 64; p < d * 64 + 64; p++)
            if (an_s[p] == m) c++;
        return c;
    endfunction

    function automatic logic [3:0] an_of(input int d);
        logic [3:0] m;
        m = ~(4'b0001 << d);
        return m;
    endfunction

    initial begin
        logic [6:0] exp_seg [4];
        int cyc;
        logic blank0;

        reset = 1'b1;
        number = 16'h8F10; dots = 4'h0; digit_enable = 4'hF;
        blank_lz = 1'b0; brightness = 2'd3; number3 = 12'h210;

        // 1. reset
        repeat (3) begin
            @(negedge clk);
            chk("rst_an", anodes, 4'hF);
            chk("rst_seg", seven_segments, 7'h7F);
            chk("rst_dot", dot, 1);
            chk("rst_fs", frame_start, 0);
        end
        reset = 1'b0;
        cyc = 0;
        blank0 = 1'b1;
        while (!frame_start && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (anodes != 4'hF || seven_segments != 7'h7F || dot != 1'b1) blank0 = 1'b0;
        end
        chk("fs_first_cycle", cyc, 256);
        chk("frame0_blank", blank0, 1);

        // 2. scan of 8F10
        exp_seg[0] = 7'h40; exp_seg[1] = 7'h79; exp_seg[2] = 7'h0E; exp_seg[3] = 7'h00;
        measure_frame(-1, 16'h0);
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("scan_an%0d", d), an_s[d*64+32], an_of(d));
            chk($sformatf("scan_seg%0d", d), seg_s[d*64+32], exp_seg[d]);
            chk($sformatf("scan_dead%0d", d), an_s[d*64], 4'hF);
            chk($sformatf("scan_lit%0d", d), lit_cnt(d), 63);
        end
        chk("fs_boundary", frame_start, 1);

        // 3. leading-zero blanking
        number = 16'h0005; blank_lz = 1'b1; dots = 4'hF;
        new_frame();
        measure_frame(-1, 16'h0);
        chk("lz_seg0", seg_s[32], 7'h12);
        chk("lz_dot0", dot_s[32], 0);
        for (int d = 1; d < 4; d++) begin
            chk($sformatf("lz_an%0d", d), lit_cnt(d), 0);
            chk($sformatf("lz_dot%0d", d), dot_s[d*64+32], 1);
        end
        number = 16'h0000;
        new_frame();
        measure_frame(-1, 16'h0);
        chk("lz_zero_seg0", seg_s[32], 7'h40);
        chk("lz_zero_an0", an_s[32], 4'hE);

        // 4. brightness
        number = 16'h8F10; blank_lz = 1'b0; dots = 4'h0; brightness = 2'd1;
        new_frame();
        measure_frame(-1, 16'h0);
        chk("br1_lit0", lit_cnt(0), 31);
        chk("br1_lit2", lit_cnt(2), 31);
        chk("br1_on31", an_s[31], 4'hE);
        chk("br1_off32", an_s[32], 4'hF);
        brightness = 2'd0;
        new_frame();
        measure_frame(-1, 16'h0);
        chk("br0_lit1", lit_cnt(1), 15);
        chk("br0_on15", an_s[64+15], 4'hD);
        chk("br0_off16", an_s[64+16], 4'hF);

        // 5. frame coherence
        brightness = 2'd3; number = 16'h1111;
        new_frame();
        measure_frame(80, 16'h2222);
        chk("coh_seg2", seg_s[2*64+32], 7'h79);
        chk("coh_seg3", seg_s[3*64+32], 7'h79);
        wait_frame();
        measure_frame(-1, 16'h0);
        for (int d = 0; d < 4; d++)
            chk($sformatf("coh_next%0d", d), seg_s[d*64+32], 7'h24);

        // 6. enable mask
        number = 16'h8F10; digit_enable = 4'b0101;
        new_frame();
        measure_frame(-1, 16'h0);
        chk("msk_lit0", lit_cnt(0), 63);
        chk("msk_lit1", lit_cnt(1), 0);
        chk("msk_lit2", lit_cnt(2), 63);
        chk("msk_lit3", lit_cnt(3), 0);

        // 3-digit instance: slots 0,1,2 then back to 0
        cyc = 0;
        @(negedge clk);
        while (!frame_start3 && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        chk("n3_fs", frame_start3, 1);
        for (int p = 0; p < 256; p++) begin
            @(negedge clk);
            if (p == 32)  chk("n3_an_slot0", anodes3, 3'b110);
            if (p == 96)  begin
                chk("n3_an_slot1", anodes3, 3'b101);
                chk("n3_seg_slot1", seven_segments3, 7'h79);
            end
            if (p == 160) chk("n3_an_slot2", anodes3, 3'b011);
            if (p == 192) chk("n3_dead_wrap", anodes3, 3'b111);
            if (p == 224) chk("n3_an_wrap0", anodes3, 3'b110);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
